// File: rtl/sudoku_sched_pkg.sv
// Shared constants and encodings for the sudoku pipeline slot scheduler.
package sudoku_sched_pkg;

    // Default configuration of the scheduler.
    localparam int DEF_NUM_SLOTS = 6;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_ITER  = 32;

    // Lap counter width; MAX_ITER is limited to 2..255 so laps fit in 8 bits.
    localparam int ITER_W = 8;

    // Index width for a field that must address n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widths of the default configuration.
    localparam int SLOT_W = idx_width(DEF_NUM_SLOTS);
    localparam int TAG_W  = idx_width(DEF_NUM_REQ);
    localparam int OCC_W  = idx_width(DEF_NUM_SLOTS + 1);

    // Reason a puzzle leaves the pipeline; 2'b11 is never produced.
    typedef enum logic [1:0] {
        ST_SOLVED  = 2'b00,
        ST_STUCK   = 2'b01,
        ST_TIMEOUT = 2'b10
    } ret_status_e;

endpackage

// File: rtl/sudoku_rr_arb.sv
// Round-robin arbiter: the first requester at or above ptr wins, otherwise
// the lowest requester below ptr wins. Purely combinational.
module sudoku_rr_arb
    import sudoku_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [idx_width(NUM_REQ)-1:0]   ptr,
    input  logic                            en,
    output logic [NUM_REQ-1:0]              grant,
    output logic [idx_width(NUM_REQ)-1:0]   winner,
    output logic                            found
);

    localparam int TW = idx_width(NUM_REQ);

    // Two passes: upper segment [ptr..N-1] first, then the wrap-around segment.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (en && !found && req[j] && (TW'(j) >= ptr)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                winner   = TW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                winner   = TW'(j);
            end
        end
    end

endmodule

// File: rtl/sudoku_pipe_sched.sv
// Slot scheduler for the rotating sudoku solver pipeline: tracks which slot
// holds which requester's puzzle, decides retire vs. recirculate at the head,
// and refills free head slots round-robin from the requesters.
module sudoku_pipe_sched
    import sudoku_sched_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_ITER  = DEF_MAX_ITER
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                go,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic                                res_solved,
    input  logic                                res_progress,
    input  logic                                ret_ready,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                load,
    output logic [idx_width(NUM_SLOTS)-1:0]     slot_ptr,
    output logic                                ret_valid,
    output logic [idx_width(NUM_REQ)-1:0]       ret_tag,
    output logic [1:0]                          ret_status,
    output logic [ITER_W-1:0]                   ret_iters,
    output logic [idx_width(NUM_SLOTS+1)-1:0]   occupancy
);

    localparam int PW = idx_width(NUM_SLOTS);
    localparam int TW = idx_width(NUM_REQ);
    localparam int CW = idx_width(NUM_SLOTS + 1);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [PW-1:0]     PTR_LAST  = PW'(NUM_SLOTS - 1);
    localparam logic [TW-1:0]     TAG_LAST  = TW'(NUM_REQ - 1);

    // Per-slot tables plus head pointer, round-robin pointer and fill count.
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [TW-1:0]        tag_q  [NUM_SLOTS];
    logic [TW-1:0]        tag_d  [NUM_SLOTS];
    logic [ITER_W-1:0]    iter_q [NUM_SLOTS];
    logic [ITER_W-1:0]    iter_d [NUM_SLOTS];
    logic [PW-1:0]        slot_ptr_q, slot_ptr_d;
    logic [TW-1:0]        rr_q, rr_d;
    logic [CW-1:0]        occ_cnt_q, occ_cnt_d;

    // Head slot view and decision signals.
    logic                 advance;
    logic                 head_occ;
    logic [TW-1:0]        head_tag;
    logic [ITER_W-1:0]    head_iter;
    logic                 want_retire;
    ret_status_e          head_status;
    logic                 ret_fire;
    logic                 head_free;

    // Arbiter results.
    logic [NUM_REQ-1:0]   arb_grant;
    logic [TW-1:0]        arb_winner;
    logic                 arb_found;

    // A cycle held in reset is not an advance: Mealy outputs stay quiet and
    // in-flight puzzles are dropped without a retire.
    assign advance = go & rst;

    // Select the head slot's table entry.
    always_comb begin
        head_occ  = 1'b0;
        head_tag  = '0;
        head_iter = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (PW'(s) == slot_ptr_q) begin
                head_occ  = occ_q[s];
                head_tag  = tag_q[s];
                head_iter = iter_q[s];
            end
        end
    end

    // Head decision in priority order: solved, no progress, out of laps.
    always_comb begin
        want_retire = 1'b0;
        head_status = ST_SOLVED;
        if (head_occ) begin
            if (res_solved) begin
                want_retire = 1'b1;
                head_status = ST_SOLVED;
            end else if (!res_progress) begin
                want_retire = 1'b1;
                head_status = ST_STUCK;
            end else if (head_iter == ITER_LAST) begin
                want_retire = 1'b1;
                head_status = ST_TIMEOUT;
            end
        end
    end

    // Retire handshake: ret_valid is raised only in a cycle where the sink
    // shows ret_ready and the head wants to leave, so every ret_valid pulse is
    // a completed transfer. Without ret_ready the puzzle recirculates and the
    // same decision is retried on its next lap.
    assign ret_fire  = advance & head_occ & want_retire & ret_ready;
    assign head_free = advance & (~head_occ | ret_fire);

    sudoku_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (rr_q),
        .en     (head_free),
        .grant  (arb_grant),
        .winner (arb_winner),
        .found  (arb_found)
    );

    assign grant      = arb_grant;
    assign load       = arb_found;
    assign ret_valid  = ret_fire;
    assign ret_tag    = ret_fire ? head_tag : '0;
    assign ret_status = ret_fire ? head_status : ST_SOLVED;
    assign ret_iters  = ret_fire ? (head_iter + ITER_W'(1)) : '0;
    assign slot_ptr   = slot_ptr_q;
    assign occupancy  = occ_cnt_q;

    // Next state: load beats retire on the head slot, otherwise recirculate.
    always_comb begin
        occ_d      = occ_q;
        tag_d      = tag_q;
        iter_d     = iter_q;
        slot_ptr_d = slot_ptr_q;
        rr_d       = rr_q;
        occ_cnt_d  = occ_cnt_q;
        if (advance) begin
            slot_ptr_d = (slot_ptr_q == PTR_LAST) ? '0 : slot_ptr_q + PW'(1);
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (PW'(s) == slot_ptr_q) begin
                    if (load) begin
                        occ_d[s]  = 1'b1;
                        tag_d[s]  = arb_winner;
                        iter_d[s] = '0;
                    end else if (ret_fire) begin
                        occ_d[s]  = 1'b0;
                        iter_d[s] = '0;
                    end else if (occ_q[s]) begin
                        iter_d[s] = (iter_q[s] == ITER_LAST) ? iter_q[s]
                                                              : iter_q[s] + ITER_W'(1);
                    end
                end
            end
            if (load) begin
                rr_d = (arb_winner == TAG_LAST) ? '0 : arb_winner + TW'(1);
            end
            occ_cnt_d = occ_cnt_q + CW'(load) - CW'(ret_fire);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q      <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                tag_q[s]  <= '0;
                iter_q[s] <= '0;
            end
            slot_ptr_q <= '0;
            rr_q       <= '0;
            occ_cnt_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            tag_q      <= tag_d;
            iter_q     <= iter_d;
            slot_ptr_q <= slot_ptr_d;
            rr_q       <= rr_d;
            occ_cnt_q  <= occ_cnt_d;
        end
    end

endmodule
